// File: rtl/dfx_packet_encap_if.sv
// Strobe-in / flit-out bus of the DFX packet encapsulator.
// flit_parity exists only when DFX_ENCAP_PARITY_EN is defined.
interface dfx_packet_encap_if #(
  parameter int DATA_WIDTH    = 1024,
  parameter int ADDR_WIDTH    = 10,
  parameter int FLIT_WIDTH    = 256,
  parameter int NODE_ID_WIDTH = 4
);
  logic                             valid_dfx_data;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] dfx_data;
  logic [NODE_ID_WIDTH-1:0]         dst_node;
  logic                             encap_busy;
  logic                             pkt_done;
  logic                             drop_err;
  logic [FLIT_WIDTH-1:0]            flit_out;
  logic [1:0]                       flit_type;
  logic                             flit_valid;
  logic                             flit_ready;
`ifdef DFX_ENCAP_PARITY_EN
  logic                             flit_parity;
`endif

  // master: fetch stage + router lane side; slave: the encapsulator
  modport master (
`ifdef DFX_ENCAP_PARITY_EN
    input  flit_parity,
`endif
    output valid_dfx_data, dfx_data, dst_node, flit_ready,
    input  encap_busy, pkt_done, drop_err, flit_out, flit_type, flit_valid
  );

  modport slave (
`ifdef DFX_ENCAP_PARITY_EN
    output flit_parity,
`endif
    input  valid_dfx_data, dfx_data, dst_node, flit_ready,
    output encap_busy, pkt_done, drop_err, flit_out, flit_type, flit_valid
  );
endinterface

// File: rtl/dfx_packet_encap.sv
// Wraps one DFX fetch result into a head + NUM_BODY body flits router packet.
// Optional even flit parity output under macro DFX_ENCAP_PARITY_EN.
module dfx_packet_encap #(
  parameter int DATA_WIDTH    = 1024,
  parameter int ADDR_WIDTH    = 10,
  parameter int FLIT_WIDTH    = 256,
  parameter int NODE_ID_WIDTH = 4,
  parameter int SRC_NODE_ID   = 0
) (
  input logic              clk,
  input logic              rst,
  dfx_packet_encap_if.slave bus
);
  localparam int NUM_BODY = DATA_WIDTH / FLIT_WIDTH;
  localparam int CNT_W    = (NUM_BODY > 1) ? $clog2(NUM_BODY) : 1;
  localparam int HDR_W    = ADDR_WIDTH + 2*NODE_ID_WIDTH + 8;

  localparam logic [1:0] S_IDLE = 2'd0, S_HEAD = 2'd1, S_BODY = 2'd2;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10;

  logic [1:0]            state, state_n;
  logic [CNT_W-1:0]      body_cnt, body_cnt_n;
  logic [DATA_WIDTH-1:0] payload, payload_n;
  logic [7:0]            seq;
  logic [FLIT_WIDTH-1:0] flit_q, flit_n;
  logic [1:0]            type_q, type_n;
  logic                  valid_q, valid_n;
  logic                  busy_q, done_q, drop_q;
  logic                  accept, last_acc;
  logic [HDR_W-1:0]      head;

  assign accept   = valid_q & bus.flit_ready;
  assign last_acc = (state == S_BODY) && accept && (body_cnt == CNT_W'(NUM_BODY-1));
  assign head     = {seq, bus.dst_node, NODE_ID_WIDTH'(SRC_NODE_ID), bus.dfx_data[ADDR_WIDTH-1:0]};

  // Next flit is computed here and registered, so flit_ready never reaches an output combinationally.
  // The payload register shifts down one flit per accept, so the LSB chunk is always next.
  always_comb begin
    state_n    = state;
    body_cnt_n = body_cnt;
    payload_n  = payload;
    flit_n     = flit_q;
    type_n     = type_q;
    valid_n    = valid_q;
    case (state)
      S_IDLE: if (bus.valid_dfx_data) begin
        state_n   = S_HEAD;
        payload_n = bus.dfx_data[ADDR_WIDTH +: DATA_WIDTH];
        flit_n    = FLIT_WIDTH'(head);
        type_n    = T_HEAD;
        valid_n   = 1'b1;
      end
      S_HEAD: if (accept) begin
        state_n    = S_BODY;
        body_cnt_n = '0;
        flit_n     = payload[FLIT_WIDTH-1:0];
        payload_n  = payload >> FLIT_WIDTH;
        type_n     = (NUM_BODY == 1) ? T_TAIL : T_BODY;
      end
      S_BODY: if (accept) begin
        if (body_cnt == CNT_W'(NUM_BODY-1)) begin
          state_n = S_IDLE;
          valid_n = 1'b0;
        end else begin
          body_cnt_n = body_cnt + CNT_W'(1);
          flit_n     = payload[FLIT_WIDTH-1:0];
          payload_n  = payload >> FLIT_WIDTH;
          type_n     = (body_cnt_n == CNT_W'(NUM_BODY-1)) ? T_TAIL : T_BODY;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef DFX_ENCAP_PARITY_EN
  logic par_q;
  assign bus.flit_parity = par_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) par_q <= 1'b0;
    else     par_q <= ^{type_n, flit_n};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      body_cnt <= '0;
      payload  <= '0;
      seq      <= '0;
      flit_q   <= '0;
      type_q   <= T_BODY;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state    <= state_n;
      body_cnt <= body_cnt_n;
      payload  <= payload_n;
      flit_q   <= flit_n;
      type_q   <= type_n;
      valid_q  <= valid_n;
      busy_q   <= (state_n != S_IDLE);
      done_q   <= last_acc;
      if (last_acc) seq <= seq + 8'd1;
      if (bus.valid_dfx_data && state != S_IDLE) drop_q <= 1'b1;
    end
  end

  assign bus.flit_out   = flit_q;
  assign bus.flit_type  = type_q;
  assign bus.flit_valid = valid_q;
  assign bus.encap_busy = busy_q;
  assign bus.pkt_done   = done_q;
  assign bus.drop_err   = drop_q;
endmodule

// File: tb/tb_dfx_packet_encap.sv
// Directed bench for dfx_packet_encap: basic packet, backpressure, drop,
// async reset mid-packet, back-to-back with seq wrap, optional parity.
module tb_dfx_packet_encap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ticks  = 0;
  int   t0;
  logic [1023:0] pl;

  always #5 clk = ~clk;

  dfx_packet_encap_if #(.DATA_WIDTH(1024), .ADDR_WIDTH(10), .FLIT_WIDTH(256), .NODE_ID_WIDTH(4)) bus ();
  dfx_packet_encap #(.DATA_WIDTH(1024), .ADDR_WIDTH(10), .FLIT_WIDTH(256),
                     .NODE_ID_WIDTH(4), .SRC_NODE_ID(0)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  task automatic strobe(input logic [1023:0] p, input logic [9:0] a, input logic [3:0] d);
    bus.valid_dfx_data = 1'b1;
    bus.dfx_data       = {p, a};
    bus.dst_node       = d;
    tick();
    bus.valid_dfx_data = 1'b0;
  endtask

  function automatic logic [255:0] head_exp(input logic [9:0] a, input logic [3:0] d, input logic [7:0] s);
    return 256'({s, d, 4'h0, a});
  endfunction

  function automatic logic [1023:0] mkpl(input logic [7:0] base, input logic [7:0] tag);
    logic [1023:0] r;
    for (int k = 0; k < 4; k++) r[k*256 +: 256] = {{31{base}}, tag + 8'(k)};
    return r;
  endfunction

  task automatic chk_flit(input string tag, input logic [255:0] d, input logic [1:0] t);
    chk1({tag, ".valid"}, bus.flit_valid, 1'b1);
    chkw({tag, ".data"}, bus.flit_out, d);
    chkw({tag, ".type"}, 256'(bus.flit_type), 256'(t));
`ifdef DFX_ENCAP_PARITY_EN
    chk1({tag, ".parity"}, bus.flit_parity, ^{t, d});
`endif
  endtask

  initial begin
    bus.valid_dfx_data = 1'b0;
    bus.dfx_data       = '0;
    bus.dst_node       = '0;
    bus.flit_ready     = 1'b0;

    // reset state
    tick();
    chk1("rst.valid", bus.flit_valid, 1'b0);
    chkw("rst.data", bus.flit_out, 256'd0);
    chkw("rst.type", 256'(bus.flit_type), 256'd0);
    chk1("rst.busy", bus.encap_busy, 1'b0);
    chk1("rst.done", bus.pkt_done, 1'b0);
    chk1("rst.drop", bus.drop_err, 1'b0);
`ifdef DFX_ENCAP_PARITY_EN
    chk1("rst.parity", bus.flit_parity, 1'b0);
`endif
    rst = 1'b0;

    // 1: basic packet, ready always high
    bus.flit_ready = 1'b1;
    pl = mkpl(8'hA5, 8'h00);
    strobe(pl, 10'h155, 4'h3);
    t0 = ticks;
    chk_flit("t1.head", head_exp(10'h155, 4'h3, 8'd0), 2'b01);
    chk1("t1.busy_h", bus.encap_busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_flit("t1.body", pl[k*256 +: 256], (k == 3) ? 2'b10 : 2'b00);
      chk1("t1.busy_b", bus.encap_busy, 1'b1);
      chk1("t1.nodone", bus.pkt_done, 1'b0);
    end
    tick();
    chk1("t1.done", bus.pkt_done, 1'b1);
    chk1("t1.valid_off", bus.flit_valid, 1'b0);
    chk1("t1.busy_off", bus.encap_busy, 1'b0);
    chki("t1.latency", ticks - t0, 5);
    tick();
    chk1("t1.done_pulse", bus.pkt_done, 1'b0);

    // 2: backpressure, 3 stalls on head, 2 on body 2
    pl = mkpl(8'h3C, 8'h10);
    bus.flit_ready = 1'b0;
    strobe(pl, 10'h2AA, 4'hC);
    t0 = ticks;
    chk_flit("t2.head", head_exp(10'h2AA, 4'hC, 8'd1), 2'b01);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_flit("t2.head_stall", head_exp(10'h2AA, 4'hC, 8'd1), 2'b01);
    end
    bus.flit_ready = 1'b1;
    tick(); chk_flit("t2.body0", pl[255:0], 2'b00);
    tick(); chk_flit("t2.body1", pl[511:256], 2'b00);
    tick(); chk_flit("t2.body2", pl[767:512], 2'b00);
    bus.flit_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk_flit("t2.body2_stall", pl[767:512], 2'b00);
      chk1("t2.nodone", bus.pkt_done, 1'b0);
    end
    bus.flit_ready = 1'b1;
    tick(); chk_flit("t2.tail", pl[1023:768], 2'b10);
    tick();
    chk1("t2.done", bus.pkt_done, 1'b1);
    chki("t2.latency", ticks - t0, 10);

    // 3: second strobe two cycles after the first is dropped
    pl = mkpl(8'h96, 8'h20);
    strobe(pl, 10'h0F0, 4'h7);
    chk_flit("t3.head", head_exp(10'h0F0, 4'h7, 8'd2), 2'b01);
    tick();
    chk_flit("t3.body0", pl[255:0], 2'b00);
    strobe(mkpl(8'hFF, 8'hF0), 10'h3FF, 4'hF);
    chk_flit("t3.body1", pl[511:256], 2'b00);
    chk1("t3.drop", bus.drop_err, 1'b1);
    tick(); chk_flit("t3.body2", pl[767:512], 2'b00);
    tick(); chk_flit("t3.tail", pl[1023:768], 2'b10);
    tick(); chk1("t3.done", bus.pkt_done, 1'b1);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk1("t3.no_second", bus.flit_valid, 1'b0);
      chk1("t3.idle", bus.encap_busy, 1'b0);
      chk1("t3.drop_sticky", bus.drop_err, 1'b1);
    end

    // 5: async reset while body 1 is presented
    pl = mkpl(8'h11, 8'h30);
    strobe(pl, 10'h001, 4'h1);
    chk_flit("t5.head", head_exp(10'h001, 4'h1, 8'd3), 2'b01);
    tick();
    tick(); chk_flit("t5.body1", pl[511:256], 2'b00);
    #2 rst = 1'b1;
    #1;
    chk1("t5.async_valid", bus.flit_valid, 1'b0);
    chk1("t5.async_busy", bus.encap_busy, 1'b0);
    chk1("t5.async_drop", bus.drop_err, 1'b0);
    tick();
    rst = 1'b0;
    pl = mkpl(8'h22, 8'h40);
    strobe(pl, 10'h123, 4'h9);
    chk_flit("t5.fresh_head", head_exp(10'h123, 4'h9, 8'd0), 2'b01);
    chk1("t5.drop", bus.drop_err, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_flit("t5.body", pl[k*256 +: 256], (k == 3) ? 2'b10 : 2'b00);
    end
    tick();
    chk1("t5.done", bus.pkt_done, 1'b1);

    // 4: 257 back-to-back packets, seq wraps 255 -> 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 257; p++) begin
      strobe(mkpl(8'h5A, 8'(p)), 10'(p), 4'(p));
      chk_flit("t4.head", head_exp(10'(p), 4'(p), 8'(p)), 2'b01);
      repeat (5) tick();
      chk1("t4.done", bus.pkt_done, 1'b1);
    end
    chk1("t4.drop", bus.drop_err, 1'b0);
    tick();
    chk1("t4.idle", bus.flit_valid, 1'b0);
    chk1("t4.done_pulse", bus.pkt_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dfx_packet_encap.md
Name: dfx_packet_encap

Overview:
- Downstream of the DFX data fetch stage: consumes the one-cycle `valid_dfx_data` / `dfx_data` pulse ({payload, v_dst_addr}).
- Builds one router packet from it: a head flit followed by payload body flits, the last one marked tail.
- Drives the packet into a router input lane over a valid/ready flit interface.
- Reports drops, busy status and packet completion back to the send controller.

Parameters:
- DATA_WIDTH, 1024, payload width inside dfx_data
- ADDR_WIDTH, 10, VRF destination address width
- FLIT_WIDTH, 256, flit payload width; DATA_WIDTH must be an integer multiple of FLIT_WIDTH
- NODE_ID_WIDTH, 4, router node id width
- SRC_NODE_ID, 0, this node's id, placed in the head flit

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_dfx_data  in  1  one-cycle strobe: dfx_data valid
- dfx_data  in  DATA_WIDTH+ADDR_WIDTH  {payload, v_dst_addr}; v_dst_addr = low ADDR_WIDTH bits
- dst_node  in  NODE_ID_WIDTH  destination node, sampled with valid_dfx_data
- encap_busy  out  1  high whenever state != IDLE
- pkt_done  out  1  one-cycle pulse after the tail flit is accepted
- drop_err  out  1  sticky: a strobe arrived while busy; cleared only by rst
- flit_out  out  FLIT_WIDTH  flit data
- flit_type  out  2  01 head, 00 body, 10 tail
- flit_valid  out  1  flit_out/flit_type valid
- flit_ready  in  1  router lane accepts the flit

Behaviour:
- Reset (async, immediate), all outputs registered: flit_valid=0, flit_out=0, flit_type=00, encap_busy=0, pkt_done=0, drop_err=0, seq=0, state=IDLE.
- NUM_BODY = DATA_WIDTH/FLIT_WIDTH (default 4); a packet is 1 head + NUM_BODY flits.
- Head flit layout, LSB-aligned, remaining upper bits zero: [ADDR_WIDTH-1:0] v_dst_addr, then SRC_NODE_ID, then dst_node, then seq[7:0].
- Body flit k (k = 0..NUM_BODY-1) = payload[k*FLIT_WIDTH +: FLIT_WIDTH], LSB chunk first. Flit k = NUM_BODY-1 has flit_type = 10 (tail).
- FSM states:
  - IDLE: on valid_dfx_data, latch payload, v_dst_addr, dst_node. Next cycle: HEAD, flit_valid=1, head presented (1-cycle latency).
  - HEAD: on flit_valid & flit_ready, go to BODY with body_cnt=0 and present body 0.
  - BODY: on each accept, body_cnt++. On accept with body_cnt = NUM_BODY-1: flit_valid=0, pkt_done=1 for 1 cycle, seq += 1 (mod 256), go to IDLE.
- Handshake:
  - flit_out and flit_type held stable while flit_valid & !flit_ready.
  - flit_valid never drops without an accept, except on rst.
  - No combinational path from flit_ready to any output.
- Throughput: with flit_ready held 1, one packet every NUM_BODY+2 cycles (6 by default). A new strobe is accepted only in IDLE, including the cycle pkt_done is high.
- Strobe while state != IDLE: ignored, latched data unchanged, drop_err set.
- rst mid-packet: flit_valid drops immediately; the partial packet is abandoned; seq returns to 0.

Optional Feature:
- Macro: DFX_ENCAP_PARITY_EN.
- Defined: extra output port `flit_parity` (out, 1) = even parity over {flit_type, flit_out}. Registered together with the flit and held stable under backpressure. Reset value 0.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
1. Basic packet:
   - Stimulus: rst pulse; flit_ready=1; strobe with payload = 1024'h{4{256'hA5..}} pattern, v_dst_addr=10'h155, dst_node=4'h3.
   - Response: head at +1 cycle (low bits 0x155, SRC 0, dst 3, seq 0); 4 body flits; last has flit_type=10; pkt_done 1 cycle after tail; encap_busy high 5 cycles.
2. Backpressure:
   - Stimulus: flit_ready low for 3 cycles on head and 2 cycles on body 2.
   - Response: flit_out/flit_type stable throughout each stall; flit order and contents unchanged; pkt_done delayed by 5 cycles.
3. Drop:
   - Stimulus: second strobe 2 cycles after the first.
   - Response: drop_err=1 and stays 1; first packet contents intact; no second packet emitted.
4. Back-to-back with seq wrap:
   - Stimulus: 257 packets, each strobe issued in the pkt_done cycle of the previous.
   - Response: no drops; head seq runs 0..255 then 0.
5. Reset mid-packet:
   - Stimulus: rst asserted while presenting body 1, then a fresh strobe.
   - Response: flit_valid=0 asynchronously; next packet starts with a head flit with seq=0; drop_err=0.
6. Parity (DFX_ENCAP_PARITY_EN defined):
   - Stimulus: head flit with known bits.
   - Response: flit_parity = XOR of {flit_type, flit_out} for every flit, including during stalls.
